// File: rtl/key_operand_loader.sv
// ---------------------------------------------------------------------------
// key_operand_loader
//
// Operand front end for the board-level 6-bit adder. A single bouncy,
// active-low push-button is synchronised, debounced and edge-detected. Each
// accepted press steps a small FSM that latches the switch bank first as
// operand one, then as operand two, and then clears the valid flag.
//
// Ports
//   i_CLOCK_POS     in   1     rising-edge clock
//   i_RESET_POS     in   1     asynchronous reset, active-high
//   i_KEY_NEG       in   1     raw push-button, active-low, asynchronous
//   i_VECTOR_IN     in   SIZE  switch operand, quasi-static
//   o_VECTOR_ONE    out  SIZE  latched operand one
//   o_VECTOR_TWO    out  SIZE  latched operand two
//   o_BIT_VALID     out  1     high while both operands are loaded
//   o_BIT_PRESS     out  1     one-cycle pulse per accepted press
//   o_VECTOR_STATE  out  2     current FSM state code
// ---------------------------------------------------------------------------
module key_operand_loader #(
    parameter int SIZE            = 6,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic            i_CLOCK_POS,
    input  logic            i_RESET_POS,
    input  logic            i_KEY_NEG,
    input  logic [SIZE-1:0] i_VECTOR_IN,
    output logic [SIZE-1:0] o_VECTOR_ONE,
    output logic [SIZE-1:0] o_VECTOR_TWO,
    output logic            o_BIT_VALID,
    output logic            o_BIT_PRESS,
    output logic [1:0]      o_VECTOR_STATE
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD_A = 2'b00,
        ST_LOAD_B = 2'b01,
        ST_SHOW   = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    // Input conditioning state
    logic             sync1_q, sync2_q;
    logic             key_db_q, key_db_d;
    logic             key_db_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_evt;

    // Operand / FSM state
    state_t           state_q, state_d;
    logic [SIZE-1:0]  one_q, one_d;
    logic [SIZE-1:0]  two_q, two_d;
    logic             valid_q, valid_d;
    logic             press_q, press_d;

    // ---- stage: synchroniser and debounce registers ----
    always_ff @(posedge i_CLOCK_POS or posedge i_RESET_POS) begin
        if (i_RESET_POS) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            key_db_q      <= 1'b1;
            key_db_prev_q <= 1'b1;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= i_KEY_NEG;
            sync2_q       <= sync1_q;
            key_db_q      <= key_db_d;
            key_db_prev_q <= key_db_q;
            cnt_q         <= cnt_d;
        end
    end

    // The counter only runs while the synchronised level disagrees with the
    // accepted level; any agreeing cycle throws the partial count away, so
    // a glitch shorter than DEBOUNCE_CYCLES never reaches key_db.
    always_comb begin
        key_db_d = key_db_q;
        cnt_d    = '0;
        if (sync2_q != key_db_q) begin
            if (cnt_q == CNT_LAST) begin
                key_db_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Falling edge of the debounced level only; releases are ignored.
    assign press_evt = key_db_prev_q & ~key_db_q;

    // ---- stage: FSM and operand registers ----
    always_ff @(posedge i_CLOCK_POS or posedge i_RESET_POS) begin
        if (i_RESET_POS) begin
            state_q <= ST_LOAD_A;
            one_q   <= '0;
            two_q   <= '0;
            valid_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            one_q   <= one_d;
            two_q   <= two_d;
            valid_q <= valid_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        state_d = state_q;
        one_d   = one_q;
        two_d   = two_q;
        valid_d = valid_q;
        press_d = press_evt;
        case (state_q)
            ST_LOAD_A: begin
                if (press_evt) begin
                    one_d   = i_VECTOR_IN;
                    state_d = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                if (press_evt) begin
                    two_d   = i_VECTOR_IN;
                    valid_d = 1'b1;
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                // Operands are intentionally held so the display keeps the
                // last sum until the next operand one is captured.
                if (press_evt) begin
                    valid_d = 1'b0;
                    state_d = ST_LOAD_A;
                end
            end
            default: begin
                // Unreachable code: recover unconditionally, leave outputs.
                state_d = ST_LOAD_A;
            end
        endcase
    end

    assign o_VECTOR_ONE   = one_q;
    assign o_VECTOR_TWO   = two_q;
    assign o_BIT_VALID    = valid_q;
    assign o_BIT_PRESS    = press_q;
    assign o_VECTOR_STATE = state_q;

endmodule

// File: tb/tb_key_operand_loader.sv
module tb_key_operand_loader;

    localparam int SIZE = 6;
    localparam int DB   = 4;

    logic            clk;
    logic            clk_en;
    logic            rst;
    logic            key;
    logic [SIZE-1:0] sw;
    logic [SIZE-1:0] one, two;
    logic            valid, press;
    logic [1:0]      state;

    int n_tests;
    int n_fail;

    key_operand_loader #(.SIZE(SIZE), .DEBOUNCE_CYCLES(DB)) dut (
        .i_CLOCK_POS   (clk),
        .i_RESET_POS   (rst),
        .i_KEY_NEG     (key),
        .i_VECTOR_IN   (sw),
        .o_VECTOR_ONE  (one),
        .o_VECTOR_TWO  (two),
        .o_BIT_VALID   (valid),
        .o_BIT_PRESS   (press),
        .o_VECTOR_STATE(state)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    // Advance n rising edges, sampling #1 after each; counts press pulses
    // and remembers the first edge index (1-based) carrying one.
    task automatic run_cycles(input int n, inout int pulses, inout int first);
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (press) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
    endtask

    // Full press/release: key low 10 edges (switch changes from 'early' to
    // 'fin' after edge 5, i.e. before the capture edge 7), then release 10.
    task automatic do_press(input logic [SIZE-1:0] early, input logic [SIZE-1:0] fin,
                            output int pulses, output int first);
        pulses = 0;
        first  = 0;
        sw  = early;
        key = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (press) begin
                pulses++;
                if (first == 0) first = i;
            end
            if (i == 5) sw = fin;
        end
        key = 1'b1;
        run_cycles(10, pulses, first);
    endtask

    task automatic test_reset;
        clk_en = 1'b0;
        key = 1'b1;
        sw  = 6'd0;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({one, two, valid, press, state} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_no_clock: one=%0d two=%0d valid=%b press=%b state=%b, required all 0",
                     one, two, valid, press, state);
        end
        clk_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_tests++;
        if ({one, two, valid, press, state} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_clocked: one=%0d two=%0d valid=%b press=%b state=%b, required all 0",
                     one, two, valid, press, state);
        end
    endtask

    task automatic test_single_press;
        int pulses, first;
        pulses = 0;
        first  = 0;
        run_cycles(3, pulses, first);
        sw  = 6'd5;
        key = 1'b0;
        pulses = 0;
        first  = 0;
        run_cycles(10, pulses, first);
        n_tests++;
        if (pulses != 1 || first != 7) begin
            n_fail++;
            $display("FAIL single_press_timing: pulses=%0d edge=%0d, required 1 at edge 7", pulses, first);
        end
        n_tests++;
        if (one !== 6'd5 || state !== 2'b01 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_press_outputs: one=%0d state=%b valid=%b, required 5/01/0", one, state, valid);
        end
        key = 1'b1;
        pulses = 0;
        first  = 0;
        run_cycles(10, pulses, first);
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL release_no_pulse: pulses=%0d, required 0", pulses);
        end
    endtask

    task automatic test_glitch;
        int pulses, first;
        pulses = 0;
        first  = 0;
        sw  = 6'd33;
        key = 1'b0;
        run_cycles(3, pulses, first);
        key = 1'b1;
        run_cycles(1, pulses, first);
        key = 1'b0;
        run_cycles(2, pulses, first);
        key = 1'b1;
        run_cycles(12, pulses, first);
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL glitch_pulse: pulses=%0d, required 0", pulses);
        end
        n_tests++;
        if (one !== 6'd5 || two !== 6'd0 || state !== 2'b01 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_hold: one=%0d two=%0d state=%b valid=%b, required 5/0/01/0",
                     one, two, state, valid);
        end
    endtask

    task automatic test_sequence;
        int pulses, first;
        #1;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        n_tests++;
        if (state !== 2'b00 || one !== 6'd0) begin
            n_fail++;
            $display("FAIL seq_reset: state=%b one=%0d, required 00/0", state, one);
        end
        // Switch moves after the debounce starts; the capture-edge value wins.
        do_press(6'd0, 6'd63, pulses, first);
        n_tests++;
        if (pulses != 1 || first != 7 || one !== 6'd63 || state !== 2'b01 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_press1: pulses=%0d edge=%0d one=%0d state=%b valid=%b, required 1/7/63/01/0",
                     pulses, first, one, state, valid);
        end
        do_press(6'd1, 6'd1, pulses, first);
        n_tests++;
        if (pulses != 1 || one !== 6'd63 || two !== 6'd1 || valid !== 1'b1 || state !== 2'b10) begin
            n_fail++;
            $display("FAIL seq_press2: pulses=%0d one=%0d two=%0d valid=%b state=%b, required 1/63/1/1/10",
                     pulses, one, two, valid, state);
        end
        do_press(6'd9, 6'd9, pulses, first);
        n_tests++;
        if (pulses != 1 || one !== 6'd63 || two !== 6'd1 || valid !== 1'b0 || state !== 2'b00) begin
            n_fail++;
            $display("FAIL seq_press3: pulses=%0d one=%0d two=%0d valid=%b state=%b, required 1/63/1/0/00",
                     pulses, one, two, valid, state);
        end
    endtask

    task automatic test_reset_mid_debounce;
        int pulses, first;
        do_press(6'd7, 6'd7, pulses, first);
        n_tests++;
        if (state !== 2'b01 || one !== 6'd7) begin
            n_fail++;
            $display("FAIL mid_setup: state=%b one=%0d, required 01/7", state, one);
        end
        sw  = 6'd12;
        key = 1'b0;
        pulses = 0;
        first  = 0;
        run_cycles(3, pulses, first);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({one, two, valid, press, state} !== 15'd0) begin
            n_fail++;
            $display("FAIL mid_reset_async: one=%0d two=%0d valid=%b press=%b state=%b, required all 0",
                     one, two, valid, press, state);
        end
        #1;
        rst = 1'b0;
        pulses = 0;
        first  = 0;
        run_cycles(10, pulses, first);
        n_tests++;
        if (pulses != 1 || first != 7 || one !== 6'd12 || state !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_reaccept: pulses=%0d edge=%0d one=%0d state=%b, required 1/7/12/01",
                     pulses, first, one, state);
        end
    endtask

    task automatic test_held_key;
        int pulses, first;
        pulses = 0;
        first  = 0;
        key = 1'b1;
        run_cycles(10, pulses, first);
        sw  = 6'd20;
        key = 1'b0;
        pulses = 0;
        first  = 0;
        run_cycles(100, pulses, first);
        n_tests++;
        if (pulses != 1 || first != 7) begin
            n_fail++;
            $display("FAIL held_low: pulses=%0d edge=%0d, required 1 at edge 7", pulses, first);
        end
        n_tests++;
        if (two !== 6'd20 || valid !== 1'b1 || state !== 2'b10) begin
            n_fail++;
            $display("FAIL held_outputs: two=%0d valid=%b state=%b, required 20/1/10", two, valid, state);
        end
        key = 1'b1;
        pulses = 0;
        first  = 0;
        run_cycles(100, pulses, first);
        n_tests++;
        if (pulses != 0 || state !== 2'b10) begin
            n_fail++;
            $display("FAIL held_release: pulses=%0d state=%b, required 0/10", pulses, state);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clk_en  = 1'b0;
        rst     = 1'b0;
        key     = 1'b1;
        sw      = '0;
        test_reset();
        test_single_press();
        test_glitch();
        test_sequence();
        test_reset_mid_debounce();
        test_held_key();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
